// File: rtl/serial_adder.sv
// Serial add/subtract unit: processes STEP bits of WIDTH-bit operands per clock, carry held in a register.
// Latency: WIDTH/STEP run cycles, then a one-cycle Done. No backpressure; Start is only sampled in IDLE/DONE.
// Optional SERIAL_ADDER_ZERO_FLAG_EN adds a registered Zero output that updates with Sum.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  localparam int NCH = WIDTH / STEP;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             sub_r;
  logic [CW-1:0]    cnt;

  logic [STEP-1:0]  a_lo;
  logic [STEP-1:0]  b_lo;
  logic [STEP-1:0]  s_lo;
  logic [STEP:0]    chunk;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] res_next;
  logic             run_shift;

  always_comb begin
    a_lo  = a_sh[STEP-1:0];
    b_lo  = b_sh[STEP-1:0] ^ {STEP{sub_r}};
    chunk = {1'b0, a_lo} + {1'b0, b_lo} + {{STEP{1'b0}}, carry};
    s_lo  = chunk[STEP-1:0];
    c_out = chunk[STEP];
    // On the last chunk this bit is the MSB, so sum ^ a ^ b recovers the carry into it.
    c_msb = s_lo[STEP-1] ^ a_lo[STEP-1] ^ b_lo[STEP-1];
  end

  assign run_shift = (state == RUN);

  // Only WIDTH-STEP result bits need storing; the final chunk goes straight to Sum.
  if (STEP == WIDTH) begin : g_single
    assign res_next = s_lo;
  end else begin : g_multi
    logic [WIDTH-STEP-1:0] res_sh;

    always_ff @(posedge CLK) begin
      if (Reset) begin
        res_sh <= '0;
      end else if (run_shift) begin
        res_sh <= res_next[WIDTH-1:STEP];
      end
    end

    assign res_next = {s_lo, res_sh};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      sub_r    <= 1'b0;
      cnt      <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
      Zero     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            sub_r <= Sub;
            carry <= Sub | Cin;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> STEP;
          b_sh  <= b_sh >> STEP;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum      <= res_next;
            Cout     <= c_out;
            Overflow <= c_msb ^ c_out;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            Zero     <= (res_next == '0);
`endif
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three WIDTH=8 instances (STEP=1,4,8) share stimulus and are compared every cycle
// against an arithmetic reference model, with hand-computed literal expectations for results and latency.
module tb_serial_adder;

  logic       CLK;
  logic       Reset;
  logic       Start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       Sub;

  logic [7:0] sum_o  [3];
  logic       cout_o [3];
  logic       ovf_o  [3];
  logic       busy_o [3];
  logic       done_o [3];
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
  logic       zero_o [3];
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // reference model state, per instance
  logic [7:0] m_sum  [3];
  logic       m_cout [3];
  logic       m_ovf  [3];
  logic       m_zero [3];
  logic       m_busy [3];
  logic       m_done [3];
  int         m_phase[3];
  logic [9:0] p_res  [3];

  serial_adder #(.WIDTH(8), .STEP(1)) u1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Sum(sum_o[0]), .Cout(cout_o[0]), .Overflow(ovf_o[0]), .Busy(busy_o[0]), .Done(done_o[0])
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    , .Zero(zero_o[0])
`endif
  );

  serial_adder #(.WIDTH(8), .STEP(4)) u4 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Sum(sum_o[1]), .Cout(cout_o[1]), .Overflow(ovf_o[1]), .Busy(busy_o[1]), .Done(done_o[1])
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    , .Zero(zero_o[1])
`endif
  );

  serial_adder #(.WIDTH(8), .STEP(8)) u8 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Sum(sum_o[2]), .Cout(cout_o[2]), .Overflow(ovf_o[2]), .Busy(busy_o[2]), .Done(done_o[2])
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    , .Zero(zero_o[2])
`endif
  );

  always #5 CLK = ~CLK;

  function automatic int nch(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
  endfunction

  // Cycles from the Start cycle to the Done cycle, and Done-to-Done spacing when back to back.
  function automatic int lat_exp(input int i);
    return (i == 0) ? 9 : ((i == 1) ? 3 : 2);
  endfunction

  // {overflow, cout, sum} from plain integer arithmetic
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
    int ua, ub, sa, sb, u, s;
    logic c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua >= ub);
    end else begin
      u = ua + ub + int'(cin);
      s = sa + sb + int'(cin);
      c = (u > 255);
    end
    return {((s > 127) || (s < -128)), c, u[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (Reset) begin
        m_sum[i] = '0; m_cout[i] = 1'b0; m_ovf[i] = 1'b0; m_zero[i] = 1'b0;
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_phase[i] = 0;
      end else if (m_busy[i]) begin
        m_phase[i]++;
        if (m_phase[i] == nch(i)) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
          {m_ovf[i], m_cout[i], m_sum[i]} = p_res[i];
          m_zero[i] = (p_res[i][7:0] == 8'h00);
        end
      end else begin
        m_done[i] = 1'b0;
        if (Start) begin
          p_res[i]   = ref_op(A, B, Cin, Sub);
          m_busy[i]  = 1'b1;
          m_phase[i] = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model busy[%0d]", i), 32'(busy_o[i]), 32'(m_busy[i]));
        chk($sformatf("model done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
        chk($sformatf("model sum[%0d]", i),  32'(sum_o[i]),  32'(m_sum[i]));
        chk($sformatf("model cout[%0d]", i), 32'(cout_o[i]), 32'(m_cout[i]));
        chk($sformatf("model ovf[%0d]", i),  32'(ovf_o[i]),  32'(m_ovf[i]));
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        chk($sformatf("model zero[%0d]", i), 32'(zero_o[i]), 32'(m_zero[i]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One Start pulse; operands are scrambled afterwards to show they are latched.
  task automatic apply_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                          input logic [7:0] es, input logic ec, input logic eo);
    int start_cyc;
    int dcyc[3];
    A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
    start_cyc = cyc;
    tick();
    Start = 1'b0;
    A = ~a; B = 8'($urandom); Cin = ~cin; Sub = ~sub;
    for (int i = 0; i < 3; i++) dcyc[i] = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        if (done_o[i] && dcyc[i] < 0) begin
          dcyc[i] = cyc;
          chk($sformatf("sum %h%s%h [%0d]", a, sub ? "-" : "+", b, i), 32'(sum_o[i]), 32'(es));
          chk($sformatf("cout %h%s%h [%0d]", a, sub ? "-" : "+", b, i), 32'(cout_o[i]), 32'(ec));
          chk($sformatf("ovf %h%s%h [%0d]", a, sub ? "-" : "+", b, i), 32'(ovf_o[i]), 32'(eo));
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
          chk($sformatf("zero %h%s%h [%0d]", a, sub ? "-" : "+", b, i), 32'(zero_o[i]), 32'(es == 8'h00));
`endif
        end
      end
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("done latency [%0d]", i), 32'(dcyc[i] - start_cyc), 32'(lat_exp(i)));
    tick();
  endtask

  logic [7:0] va [9] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h5A, 8'h80, 8'h10, 8'h00, 8'h80};
  logic [7:0] vb [9] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h5A, 8'h01, 8'h20, 8'h00, 8'h80};
  logic       vc [9] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic       vs [9] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
  logic [7:0] es [9] = '{8'h7F, 8'h01, 8'h80, 8'hF0, 8'h00, 8'h7F, 8'hF0, 8'h01, 8'h00};
  logic       ec [9] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
  logic       eo [9] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

  initial begin
    int first[3];
    int second[3];
    int dones;
    int seen;
    CLK = 1'b0;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset sum[%0d]", i),  32'(sum_o[i]),  32'h0);
      chk($sformatf("reset busy[%0d]", i), 32'(busy_o[i]), 32'h0);
      chk($sformatf("reset done[%0d]", i), 32'(done_o[i]), 32'h0);
    end
    tick();
    Reset = 1'b0;
    tick();

    for (int v = 0; v < 9; v++)
      apply_op(va[v], vb[v], vc[v], vs[v], es[v], ec[v], eo[v]);

    // reset on the fourth RUN cycle of the STEP=1 instance
    A = 8'h35; B = 8'h4A; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    idle(3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge CLK);
    chk("midreset busy", 32'(busy_o[0]), 32'h0);
    chk("midreset sum", 32'(sum_o[0]), 32'h0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (done_o[0]) dones++;
    end
    chk("midreset no done", 32'(dones), 32'h0);
    tick();

    // Start held high: back-to-back operations
    A = 8'hC3; B = 8'h2D; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    for (int i = 0; i < 3; i++) begin first[i] = -1; second[i] = -1; end
    for (int n = 0; n < 24; n++) begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        if (done_o[i]) begin
          if (first[i] < 0) first[i] = cyc;
          else if (second[i] < 0) second[i] = cyc;
        end
      end
    end
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b spacing [%0d]", i), 32'(second[i] - first[i]), 32'(lat_exp(i)));
    idle(12);

    // a second Start during RUN must not disturb the STEP=1 operation
    A = 8'h12; B = 8'h34; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    idle(2);
    A = 8'hFF; B = 8'hFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (done_o[0] && seen == 0) begin
        seen = 1;
        chk("start-in-run sum", 32'(sum_o[0]), 32'h46);
      end
    end
    chk("start-in-run done seen", 32'(seen), 32'h1);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
